// File: rtl/display_link_pkg.sv
// Shared types and constants for the seven-segment display link receiver.
// A frame is one segment byte followed by an active-low one-hot digit select.
package display_link_pkg;

    localparam int FRAME_BITS  = 16;
    localparam int SEG_BITS    = 8;
    localparam int DIGIT_COUNT = 6;
    localparam int BIT_CNT_W   = 5;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = 5'd17;

    typedef logic [SEG_BITS-1:0] seg_t;

    typedef struct packed {
        seg_t       seg_n;
        logic [7:0] sel_n;
    } frame_t;

    // Unused select bits must be high and exactly one digit line may be low.
    function automatic logic sel_is_valid(input logic [7:0] sel_n);
        int zeros;
        zeros = 0;
        for (int k = 0; k < DIGIT_COUNT; k++) begin
            if (!sel_n[k]) zeros++;
        end
        return (sel_n[7:6] == 2'b11) && (zeros == 1);
    endfunction

endpackage

// File: rtl/display_link_receiver_sync.sv
// Multi-stage synchronizer for one link input plus a registered rising-edge
// detector; rise is a one-cycle pulse SYNC_STAGES+1 cycles after the pin edge.
module link_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = rise_q;

endmodule

// File: rtl/display_link_receiver.sv
// Receiver for the serial seven-segment display link: reassembles 16-bit
// frames, rebuilds the six digit patterns and tracks framing errors/staleness.
module display_link_receiver
    import display_link_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int STALE_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ledsd_ds,
    input  logic        ledsd_shcp,
    input  logic        ledsd_stcp,
    input  logic        ledsd_bl,
    output logic [47:0] digit_n,
    output logic [5:0]  digit_fresh,
    output logic        blanked,
    output logic        frame_pulse,
    output logic        frame_error,
    output logic [15:0] frame_count
);

    localparam int STALE_W = $clog2(STALE_CYCLES + 1);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYCLES);

    logic ds_lvl, ds_rise_unused;
    logic shcp_lvl_unused, shcp_rise;
    logic stcp_lvl_unused, stcp_rise;
    logic bl_lvl, bl_rise_unused;

    link_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ds (
        .clk(clk), .reset_n(reset_n), .din(ledsd_ds),
        .level(ds_lvl), .rise(ds_rise_unused)
    );
    link_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_shcp (
        .clk(clk), .reset_n(reset_n), .din(ledsd_shcp),
        .level(shcp_lvl_unused), .rise(shcp_rise)
    );
    link_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stcp (
        .clk(clk), .reset_n(reset_n), .din(ledsd_stcp),
        .level(stcp_lvl_unused), .rise(stcp_rise)
    );
    link_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bl (
        .clk(clk), .reset_n(reset_n), .din(ledsd_bl),
        .level(bl_lvl), .rise(bl_rise_unused)
    );

    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  frame_pulse_q, frame_pulse_d;
    logic                  frame_error_q, frame_error_d;
    logic [15:0]           frame_count_q, frame_count_d;
    seg_t                  digit_q [DIGIT_COUNT];
    seg_t                  digit_d [DIGIT_COUNT];
    logic [STALE_W-1:0]    stale_q [DIGIT_COUNT];
    logic [STALE_W-1:0]    stale_d [DIGIT_COUNT];
    frame_t                frame_post;
    logic                  accept;

    // A shift landing on the same cycle as the latch is applied first, so the
    // latch check sees the post-shift register and post-increment count.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (shcp_rise) begin
            shift_d = {shift_q[FRAME_BITS-2:0], ds_lvl};
            if (bit_cnt_q != BIT_CNT_MAX) bit_cnt_d = bit_cnt_q + 5'd1;
        end

        frame_post = frame_t'(shift_d);
        accept     = stcp_rise && (bit_cnt_d == 5'(FRAME_BITS))
                     && sel_is_valid(frame_post.sel_n);

        frame_pulse_d = accept;
        frame_error_d = frame_error_q | (stcp_rise & ~accept);
        frame_count_d = frame_count_q + 16'(accept);
        if (stcp_rise) bit_cnt_d = '0;

        for (int i = 0; i < DIGIT_COUNT; i++) begin
            digit_d[i] = digit_q[i];
            stale_d[i] = (stale_q[i] != STALE_MAX) ? stale_q[i] + STALE_W'(1) : stale_q[i];
            if (accept && !frame_post.sel_n[i]) begin
                digit_d[i] = frame_post.seg_n;
                stale_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            frame_pulse_q <= 1'b0;
            frame_error_q <= 1'b0;
            frame_count_q <= '0;
            for (int i = 0; i < DIGIT_COUNT; i++) begin
                digit_q[i] <= '1;
                stale_q[i] <= STALE_MAX;
            end
        end else begin
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_pulse_q <= frame_pulse_d;
            frame_error_q <= frame_error_d;
            frame_count_q <= frame_count_d;
            for (int i = 0; i < DIGIT_COUNT; i++) begin
                digit_q[i] <= digit_d[i];
                stale_q[i] <= stale_d[i];
            end
        end
    end

    // Freshness is combinational on the counter so it drops on the cycle the
    // counter saturates.
    always_comb begin
        digit_n     = '1;
        digit_fresh = '0;
        for (int i = 0; i < DIGIT_COUNT; i++) begin
            digit_n[8*i +: 8] = digit_q[i];
            digit_fresh[i]    = stale_q[i] < STALE_MAX;
        end
    end

    assign blanked     = bl_lvl;
    assign frame_pulse = frame_pulse_q;
    assign frame_error = frame_error_q;
    assign frame_count = frame_count_q;

endmodule
